// File: rtl/cursor_measure_unit_if.sv
// cursor_measure_unit_if
// Bundles the request/result signals between the cursor/button control
// logic (master) and the cursor measurement engine (slave).
//   start          request a measurement
//   cursorx1/x2    X cursor positions
//   cursory1/y2    Y cursor positions
//   sampleadjust   packed per-wave rate factors, wave i at [i*RATE_W +: RATE_W]
//   shiftDown      packed per-wave shrink shifts, wave i at [i*SHIFT_W +: SHIFT_W]
//   waveSel        wave whose scaling applies
//   measurement    0 none, 1 dx, 2 dy, 3 dx*rate, 4 dy<<shift, 5-7 reserved
//   busy/valid     engine status, one-cycle result strobe
//   num/sat        last result and its saturation flag
interface cursor_measure_unit_if #(
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned OUT_W     = 14,
    parameter int unsigned NUM_WAVES = 4,
    parameter int unsigned RATE_W    = 6,
    parameter int unsigned SHIFT_W   = 4,
    parameter int unsigned SEL_W     = 2
) ();
    logic                         start;
    logic [COORD_W-1:0]           cursorx1;
    logic [COORD_W-1:0]           cursorx2;
    logic [COORD_W-1:0]           cursory1;
    logic [COORD_W-1:0]           cursory2;
    logic [NUM_WAVES*RATE_W-1:0]  sampleadjust;
    logic [NUM_WAVES*SHIFT_W-1:0] shiftDown;
    logic [SEL_W-1:0]             waveSel;
    logic [2:0]                   measurement;
    logic                         busy;
    logic                         valid;
    logic [OUT_W-1:0]             num;
    logic                         sat;

    modport master (
        output start, cursorx1, cursorx2, cursory1, cursory2,
               sampleadjust, shiftDown, waveSel, measurement,
        input  busy, valid, num, sat
    );

    modport slave (
        input  start, cursorx1, cursorx2, cursory1, cursory2,
               sampleadjust, shiftDown, waveSel, measurement,
        output busy, valid, num, sat
    );
endinterface

// File: rtl/cursor_measure_unit.sv
// cursor_measure_unit
// Cursor measurement engine for the scope overlay. A start strobe in IDLE
// captures the cursors and the selected wave's scaling; the engine then
// produces |a-b| raw, multiplied by the wave's rate factor (time) or
// shifted by its shrink shift (voltage), saturated to OUT_W bits.
//   clock   system clock, rising edge
//   resetn  synchronous active-low reset
//   bus     slave side of cursor_measure_unit_if (request in, result out)
module cursor_measure_unit #(
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned OUT_W     = 14,
    parameter int unsigned NUM_WAVES = 4,
    parameter int unsigned RATE_W    = 6,
    parameter int unsigned SHIFT_W   = 4,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    cursor_measure_unit_if.slave  bus
);
    localparam int unsigned MUL_W  = COORD_W + RATE_W;
    localparam int unsigned SH_W   = COORD_W + (2**SHIFT_W) - 1;
    localparam int unsigned WIDE_W = (MUL_W > SH_W) ? MUL_W : SH_W;
    localparam int unsigned CNT_W  = $clog2(RATE_W) + 1;

    typedef enum logic [1:0] {IDLE, DIFF, MUL, SHIFT} state_t;

    state_t             state, state_nxt;
    logic               diff_ph;   // DIFF spends one cycle forming d, one dispatching
    logic [COORD_W-1:0] x1_r, x2_r, y1_r, y2_r, d_r;
    logic [2:0]         mode_r;
    logic               wave_ok_r;
    logic [RATE_W-1:0]  rate_r, mult;
    logic [SHIFT_W-1:0] shift_r;
    logic [MUL_W-1:0]   acc, mcand, mul_sum;
    logic [CNT_W-1:0]   cnt;

    logic               wave_ok;
    logic [RATE_W-1:0]  rate_sel;
    logic [SHIFT_W-1:0] shift_sel;
    logic               use_y, mode_bad, mul_last;
    logic [COORD_W-1:0] op_a, op_b, d_calc;
    logic [SH_W-1:0]    sh_val;
    logic               load_en;
    logic [WIDE_W-1:0]  load_val;

    // Slice the selected wave's scaling; an out-of-range waveSel leaves wave_ok low.
    always_comb begin
        wave_ok   = 1'b0;
        rate_sel  = '0;
        shift_sel = '0;
        for (int unsigned i = 0; i < NUM_WAVES; i++) begin
            if (bus.waveSel == i[SEL_W-1:0]) begin
                wave_ok   = 1'b1;
                rate_sel  = bus.sampleadjust[i*RATE_W +: RATE_W];
                shift_sel = bus.shiftDown[i*SHIFT_W +: SHIFT_W];
            end
        end
    end

    always_comb begin
        use_y    = (mode_r == 3'd2) || (mode_r == 3'd4);
        op_a     = use_y ? y1_r : x1_r;
        op_b     = use_y ? y2_r : x2_r;
        d_calc   = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        mode_bad = !wave_ok_r || (mode_r == 3'd0) || (mode_r > 3'd4);
        mul_sum  = acc + (mult[0] ? mcand : '0);
        mul_last = (cnt == CNT_W'(RATE_W - 1));
        sh_val   = SH_W'(d_r) << shift_r;
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = DIFF;
            DIFF: begin
                if (diff_ph) begin
                    if (mode_bad || mode_r == 3'd1 || mode_r == 3'd2) state_nxt = IDLE;
                    else if (mode_r == 3'd3)                          state_nxt = MUL;
                    else                                              state_nxt = SHIFT;
                end
            end
            MUL:   if (mul_last) state_nxt = IDLE;
            SHIFT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        load_en  = 1'b0;
        load_val = '0;
        case (state)
            DIFF: begin
                if (diff_ph && mode_bad) begin
                    load_en = 1'b1;
                end else if (diff_ph && (mode_r == 3'd1 || mode_r == 3'd2)) begin
                    load_en  = 1'b1;
                    load_val = WIDE_W'(d_r);
                end
            end
            MUL: begin
                if (mul_last) begin
                    load_en  = 1'b1;
                    load_val = WIDE_W'(mul_sum);
                end
            end
            SHIFT: begin
                load_en  = 1'b1;
                load_val = WIDE_W'(sh_val);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bus.valid <= 1'b0;
            bus.num   <= '0;
            bus.sat   <= 1'b0;
            diff_ph   <= 1'b0;
            x1_r      <= '0;
            x2_r      <= '0;
            y1_r      <= '0;
            y2_r      <= '0;
            d_r       <= '0;
            mode_r    <= '0;
            wave_ok_r <= 1'b0;
            rate_r    <= '0;
            shift_r   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mult      <= '0;
            cnt       <= '0;
        end else begin
            bus.valid <= load_en;
            if (load_en) begin
                if (|load_val[WIDE_W-1:OUT_W]) begin
                    bus.num <= '1;
                    bus.sat <= 1'b1;
                end else begin
                    bus.num <= load_val[OUT_W-1:0];
                    bus.sat <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x1_r      <= bus.cursorx1;
                        x2_r      <= bus.cursorx2;
                        y1_r      <= bus.cursory1;
                        y2_r      <= bus.cursory2;
                        mode_r    <= bus.measurement;
                        wave_ok_r <= wave_ok;
                        rate_r    <= rate_sel;
                        shift_r   <= shift_sel;
                        diff_ph   <= 1'b0;
                    end
                end
                DIFF: begin
                    if (!diff_ph) begin
                        d_r     <= d_calc;
                        diff_ph <= 1'b1;
                    end else begin
                        diff_ph <= 1'b0;
                        acc     <= '0;
                        mcand   <= MUL_W'(d_r);
                        mult    <= rate_r;
                        cnt     <= '0;
                    end
                end
                MUL: begin
                    // LSB-first shift-add: fixed RATE_W iterations whatever the factor.
                    acc   <= mul_sum;
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
